// File: rtl/mips_alu.sv
// mips_alu: 32-bit MIPS integer ALU plus next-HI/LO logic; the divider (ops 14/15) exists only with ALU_DIV_EN defined.
// Latency: one CLK rising edge, all outputs registered. Backpressure: none, a new op is accepted every cycle.
module mips_alu (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALU_control,
  input  logic [4:0]  shiftAmount,
  input  logic [31:0] HI_IN,
  input  logic [31:0] LO_IN,
  output logic [31:0] aluResult,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT
);

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_ADDU  = 6'h02;
  localparam logic [5:0] OP_SUB   = 6'h03;
  localparam logic [5:0] OP_SUBU  = 6'h04;
  localparam logic [5:0] OP_AND   = 6'h05;
  localparam logic [5:0] OP_OR    = 6'h06;
  localparam logic [5:0] OP_XOR   = 6'h07;
  localparam logic [5:0] OP_NOR   = 6'h08;
  localparam logic [5:0] OP_SLT   = 6'h09;
  localparam logic [5:0] OP_SLTU  = 6'h0A;
  localparam logic [5:0] OP_SLL   = 6'h0B;
  localparam logic [5:0] OP_SRL   = 6'h0C;
  localparam logic [5:0] OP_SRA   = 6'h0D;
  localparam logic [5:0] OP_SLLV  = 6'h0E;
  localparam logic [5:0] OP_SRLV  = 6'h0F;
  localparam logic [5:0] OP_SRAV  = 6'h10;
  localparam logic [5:0] OP_LUI   = 6'h11;
  localparam logic [5:0] OP_MULT  = 6'h12;
  localparam logic [5:0] OP_MULTU = 6'h13;
`ifdef ALU_DIV_EN
  localparam logic [5:0] OP_DIV   = 6'h14;
  localparam logic [5:0] OP_DIVU  = 6'h15;
`endif
  localparam logic [5:0] OP_MFHI  = 6'h16;
  localparam logic [5:0] OP_MFLO  = 6'h17;
  localparam logic [5:0] OP_MTHI  = 6'h18;
  localparam logic [5:0] OP_MTLO  = 6'h19;
  localparam logic [5:0] OP_PASSA = 6'h1A;
  localparam logic [5:0] OP_PASSB = 6'h1B;

  logic [31:0] result_d, result_q;
  logic [31:0] hi_d, hi_q;
  logic [31:0] lo_d, lo_q;

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  // Sign/zero-extend to 64 bits so the full product is formed, not a truncated one.
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

`ifdef ALU_DIV_EN
  logic [31:0] div_q_s, div_r_s, div_q_u, div_r_u;
  logic        div_by_zero;
  logic        div_ovf;

  // Raw quotients are only selected when the divisor is nonzero and not the overflow pair.
  assign div_q_s     = $signed(A) / $signed(B);
  assign div_r_s     = $signed(A) % $signed(B);
  assign div_q_u     = A / B;
  assign div_r_u     = A % B;
  assign div_by_zero = (B == 32'h0);
  assign div_ovf     = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
`endif

  always_comb begin
    result_d = 32'h0;
    hi_d     = HI_IN;
    lo_d     = LO_IN;
    case (ALU_control)
      OP_NOP:   result_d = 32'h0;
      OP_ADD,
      OP_ADDU:  result_d = A + B;
      OP_SUB,
      OP_SUBU:  result_d = A - B;
      OP_AND:   result_d = A & B;
      OP_OR:    result_d = A | B;
      OP_XOR:   result_d = A ^ B;
      OP_NOR:   result_d = ~(A | B);
      OP_SLT:   result_d = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      OP_SLTU:  result_d = (A < B) ? 32'd1 : 32'd0;
      OP_SLL:   result_d = B << shiftAmount;
      OP_SRL:   result_d = B >> shiftAmount;
      OP_SRA:   result_d = $signed(B) >>> shiftAmount;
      OP_SLLV:  result_d = B << A[4:0];
      OP_SRLV:  result_d = B >> A[4:0];
      OP_SRAV:  result_d = $signed(B) >>> A[4:0];
      OP_LUI:   result_d = {B[15:0], 16'h0};
      OP_MULT:  {hi_d, lo_d} = prod_s;
      OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (div_by_zero) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = A;
        end else if (div_ovf) begin
          lo_d = 32'h8000_0000;
          hi_d = 32'h0;
        end else begin
          lo_d = div_q_s;
          hi_d = div_r_s;
        end
      end
      OP_DIVU: begin
        if (div_by_zero) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = A;
        end else begin
          lo_d = div_q_u;
          hi_d = div_r_u;
        end
      end
`endif
      OP_MFHI:  result_d = HI_IN;
      OP_MFLO:  result_d = LO_IN;
      OP_MTHI:  hi_d = A;
      OP_MTLO:  lo_d = A;
      OP_PASSA: result_d = A;
      OP_PASSB: result_d = B;
      default:  result_d = 32'h0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      result_q <= 32'h0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
    end else begin
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign aluResult = result_q;
  assign HI_OUT    = hi_q;
  assign LO_OUT    = lo_q;

endmodule

// File: tb/tb_mips_alu.sv
// Directed-vector bench for mips_alu; divide vectors depend on ALU_DIV_EN.
module tb_mips_alu;

  logic        CLK;
  logic        RESET;
  logic [31:0] A, B, HI_IN, LO_IN;
  logic [5:0]  ALU_control;
  logic [4:0]  shiftAmount;
  logic [31:0] aluResult, HI_OUT, LO_OUT;

  int n_chk  = 0;
  int n_pass = 0;

  mips_alu dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .A           (A),
    .B           (B),
    .ALU_control (ALU_control),
    .shiftAmount (shiftAmount),
    .HI_IN       (HI_IN),
    .LO_IN       (LO_IN),
    .aluResult   (aluResult),
    .HI_OUT      (HI_OUT),
    .LO_OUT      (LO_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Drive one op at the falling edge, then check the registered outputs just after the rising edge.
  task automatic run(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo,
                     input logic [31:0] exp_r, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge CLK);
    ALU_control = op;
    A           = a;
    B           = b;
    shiftAmount = sh;
    HI_IN       = hi;
    LO_IN       = lo;
    @(posedge CLK);
    #1;
    check({tag, ".res"}, aluResult, exp_r);
    check({tag, ".hi"},  HI_OUT,    exp_hi);
    check({tag, ".lo"},  LO_OUT,    exp_lo);
  endtask

  localparam logic [31:0] HP = 32'hAAAA_5555;
  localparam logic [31:0] LP = 32'h1357_9BDF;

  initial begin
    RESET       = 1'b1;
    A           = '0;
    B           = '0;
    ALU_control = '0;
    shiftAmount = '0;
    HI_IN       = 32'hFFFF_FFFF;
    LO_IN       = 32'hFFFF_FFFF;
    ALU_control = 6'h1A;
    A           = 32'h5A5A_5A5A;
    @(posedge CLK);
    #1;
    check("rst.res", aluResult, 32'h0);
    check("rst.hi",  HI_OUT,    32'h0);
    check("rst.lo",  LO_OUT,    32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    run("add_wrap", 6'h01, 32'h7FFF_FFFF, 32'h1, 5'd0, HP, LP, 32'h8000_0000, HP, LP);
    run("addu",     6'h02, 32'hFFFF_FFFF, 32'h2, 5'd0, HP, LP, 32'h0000_0001, HP, LP);
    run("sub",      6'h03, 32'h0, 32'h1, 5'd0, HP, LP, 32'hFFFF_FFFF, HP, LP);
    run("subu",     6'h04, 32'h10, 32'h3, 5'd0, HP, LP, 32'h0000_000D, HP, LP);
    run("and",      6'h05, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, HP, LP, 32'h0F00_0F00, HP, LP);
    run("or",       6'h06, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, HP, LP, 32'hFF0F_FF0F, HP, LP);
    run("xor",      6'h07, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, HP, LP, 32'hF00F_F00F, HP, LP);
    run("nor",      6'h08, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, HP, LP, 32'h00F0_00F0, HP, LP);
    run("slt",      6'h09, 32'hFFFF_FFFF, 32'h1, 5'd0, HP, LP, 32'h1, HP, LP);
    run("sltu",     6'h0A, 32'hFFFF_FFFF, 32'h1, 5'd0, HP, LP, 32'h0, HP, LP);
    run("sll31",    6'h0B, 32'h0, 32'h1, 5'd31, HP, LP, 32'h8000_0000, HP, LP);
    run("sll0",     6'h0B, 32'h0, 32'hDEAD_BEEF, 5'd0, HP, LP, 32'hDEAD_BEEF, HP, LP);
    run("srl",      6'h0C, 32'h0, 32'h8000_0000, 5'd4, HP, LP, 32'h0800_0000, HP, LP);
    run("sra",      6'h0D, 32'h0, 32'h8000_0000, 5'd4, HP, LP, 32'hF800_0000, HP, LP);
    run("sllv",     6'h0E, 32'hFFFF_FFE4, 32'h1, 5'd0, HP, LP, 32'h0000_0010, HP, LP);
    run("srlv",     6'h0F, 32'h24, 32'h8000_0000, 5'd0, HP, LP, 32'h0800_0000, HP, LP);
    run("srav",     6'h10, 32'h24, 32'h8000_0000, 5'd0, HP, LP, 32'hF800_0000, HP, LP);
    run("lui",      6'h11, 32'h0, 32'hABCD_1234, 5'd0, HP, LP, 32'h1234_0000, HP, LP);
    run("mult",     6'h12, 32'hFFFF_FFFE, 32'h3, 5'd0, HP, LP, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu",    6'h13, 32'hFFFF_FFFE, 32'h3, 5'd0, HP, LP, 32'h0, 32'h0000_0002, 32'hFFFF_FFFA);
`ifdef ALU_DIV_EN
    run("div_neg",  6'h14, 32'hFFFF_FFF9, 32'h2, 5'd0, HP, LP, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_z",   6'h15, 32'h5, 32'h0, 5'd0, HP, LP, 32'h0, 32'h0000_0005, 32'hFFFF_FFFF);
    run("div_z",    6'h14, 32'hFFFF_FFF0, 32'h0, 5'd0, HP, LP, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run("div_ovf",  6'h14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, HP, LP, 32'h0, 32'h0, 32'h8000_0000);
    run("divu",     6'h15, 32'd100, 32'd7, 5'd0, HP, LP, 32'h0, 32'd2, 32'd14);
`else
    run("div_off",  6'h14, 32'hFFFF_FFF9, 32'h2, 5'd0, HP, LP, 32'h0, HP, LP);
    run("divu_off", 6'h15, 32'h5, 32'h0, 5'd0, HP, LP, 32'h0, HP, LP);
`endif
    run("mthi",     6'h18, 32'h1234_5678, 32'h0, 5'd0, 32'h0, LP, 32'h0, 32'h1234_5678, LP);
    run("add_hold", 6'h01, 32'h1, 32'h1, 5'd0, 32'h1234_5678, LP, 32'h2, 32'h1234_5678, LP);
    run("mfhi",     6'h16, 32'h0, 32'h0, 5'd0, 32'h1234_5678, LP, 32'h1234_5678, 32'h1234_5678, LP);
    run("mtlo",     6'h19, 32'hCAFE_F00D, 32'h0, 5'd0, HP, LP, 32'h0, HP, 32'hCAFE_F00D);
    run("mflo",     6'h17, 32'h0, 32'h0, 5'd0, HP, 32'hCAFE_F00D, 32'hCAFE_F00D, HP, 32'hCAFE_F00D);
    run("passb",    6'h1B, 32'h1111_1111, 32'h2222_2222, 5'd0, HP, LP, 32'h2222_2222, HP, LP);
    run("nop",      6'h00, 32'h1111_1111, 32'h2222_2222, 5'd0, HP, LP, 32'h0, HP, LP);
    run("unused",   6'h3F, 32'h1111_1111, 32'h2222_2222, 5'd0, HP, LP, 32'h0, HP, LP);
    run("passa",    6'h1A, 32'hDEAD_BEEF, 32'h0, 5'd0, HP, LP, 32'hDEAD_BEEF, HP, LP);

    // Asynchronous reset mid-cycle: outputs must clear with no clock edge in between.
    #1;
    RESET = 1'b1;
    #1;
    check("arst.res", aluResult, 32'h0);
    check("arst.hi",  HI_OUT,    32'h0);
    check("arst.lo",  LO_OUT,    32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("rel.res", aluResult, 32'hDEAD_BEEF);
    check("rel.hi",  HI_OUT,    HP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
